// File: rtl/dsp_pkg.sv
// Shared DSP definitions: instruction encoding, the NOP word and the sequencer state type.
// The sequencer and the core both import this package.
package dsp_pkg;

  typedef enum logic [5:0] {
    OP_NOP    = 6'h00,
    OP_MUL    = 6'h01,
    OP_MAC    = 6'h02,
    OP_ROTMAC = 6'h03,
    OP_STORE  = 6'h04,
    OP_IN     = 6'h05,
    OP_OUT    = 6'h06
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [9:0] sample_addr;
    logic [9:0] param_addr;
  } instr_t;

  localparam instr_t INSTR_NOP = '{opcode: OP_NOP, sample_addr: 10'd0, param_addr: 10'd0};

  // Read, ex1, ex2 and writeback.
  localparam int CORE_PIPELINE_DEPTH = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dsp_sequencer_if.sv
// Frame-control, instruction-RAM and issue signals of one dsp_sequencer.
// Master is the sequencer. Slave is the frame timing logic, the RAM and the core.
interface dsp_sequencer_if #(
  parameter int INSTR_ADDR_WIDTH = 10
);

  // Handshake: frame_strobe is a one-cycle request. It is accepted only while busy
  // is low. A strobe that arrives while busy is high is dropped and raises overrun.
  // The RAM returns imem_rd_data one cycle after imem_rd_addr.
  // frame_done pulses for one cycle when the frame completes.
  logic                        frame_strobe;
  logic [INSTR_ADDR_WIDTH:0]   program_length;
  logic                        overrun_clear;
  logic [INSTR_ADDR_WIDTH-1:0] imem_rd_addr;
  dsp_pkg::instr_t             imem_rd_data;
  dsp_pkg::instr_t             instr_out;
  logic                        busy;
  logic                        frame_done;
  logic                        overrun;
  dsp_pkg::seq_state_t         dbg_state;

  modport master (
    input  frame_strobe,
    input  program_length,
    input  overrun_clear,
    input  imem_rd_data,
    output imem_rd_addr,
    output instr_out,
    output busy,
    output frame_done,
    output overrun,
    output dbg_state
  );

  modport slave (
    output frame_strobe,
    output program_length,
    output overrun_clear,
    output imem_rd_data,
    input  imem_rd_addr,
    input  instr_out,
    input  busy,
    input  frame_done,
    input  overrun,
    input  dbg_state
  );

endinterface

// File: rtl/dsp_sequencer.sv
// Frame instruction issuer. On each accepted strobe it streams L instructions from the
// instruction RAM into the core, issues NOPs while the pipeline drains, then pulses frame_done.
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = 10,
  parameter int DRAIN_CYCLES     = CORE_PIPELINE_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  dsp_sequencer_if.master bus
);

  localparam int AW = INSTR_ADDR_WIDTH;
  localparam int CW = $clog2(DRAIN_CYCLES + 2);
  // DRAIN lasts DRAIN_CYCLES+2 cycles. This covers the RAM read latency, the output
  // register, and then the pipeline depth.
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW:0]   PC_ONE     = (AW + 1)'(1);

  seq_state_t      state;
  seq_state_t      state_next;
  logic [AW:0]     pc;
  logic [AW:0]     len_q;
  logic [CW-1:0]   drain_cnt;
  logic            fetch_valid;
  instr_t          instr_q;
  logic            frame_done_q;
  logic            overrun_q;

  logic            accept;
  logic            last_fetch;
  logic            drain_end;
  logic            run;
  logic            busy_c;
  logic [AW-1:0]   rd_addr_c;

  assign accept     = bus.frame_strobe && (state == SEQ_IDLE);
  // The PC is one bit wider than the address, so a full 2^AW program ends without wrapping.
  assign last_fetch = (state == SEQ_RUN) && ((pc + PC_ONE) == len_q);
  assign drain_end  = (state == SEQ_DRAIN) && (drain_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      SEQ_IDLE: begin
        if (bus.frame_strobe) begin
          state_next = (bus.program_length == '0) ? SEQ_DRAIN : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (last_fetch) begin
          state_next = SEQ_DRAIN;
        end
      end
      SEQ_DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = SEQ_IDLE;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    run       = 1'b0;
    busy_c    = 1'b0;
    rd_addr_c = '0;
    unique case (state)
      SEQ_IDLE: begin
        run    = 1'b0;
        busy_c = 1'b0;
      end
      SEQ_RUN: begin
        run       = 1'b1;
        busy_c    = 1'b1;
        rd_addr_c = pc[AW-1:0];
      end
      SEQ_DRAIN: begin
        busy_c = 1'b1;
      end
      default: begin
        run    = 1'b0;
        busy_c = 1'b0;
      end
    endcase
  end

  // PC and length latch. The length is frozen at acceptance for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      len_q <= '0;
    end else if (accept) begin
      pc    <= '0;
      len_q <= bus.program_length;
    end else if (state == SEQ_RUN) begin
      pc <= last_fetch ? '0 : (pc + PC_ONE);
    end
  end

  // The drain counter is preloaded outside DRAIN. It counts down to zero inside DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
    end else if (state != SEQ_DRAIN) begin
      drain_cnt <= DRAIN_LOAD;
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - CNT_ONE;
    end
  end

  // Issue stage. RAM data is forwarded only when a fetch was issued in the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid  <= 1'b0;
      instr_q      <= INSTR_NOP;
      frame_done_q <= 1'b0;
    end else begin
      fetch_valid  <= run;
      instr_q      <= fetch_valid ? bus.imem_rd_data : INSTR_NOP;
      frame_done_q <= drain_end;
    end
  end

  // Sticky overrun flag. If a set and a clear arrive in the same cycle, the set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (bus.frame_strobe && (state != SEQ_IDLE)) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clear) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.imem_rd_addr = rd_addr_c;
  assign bus.instr_out    = instr_q;
  assign bus.busy         = busy_c;
  assign bus.frame_done   = frame_done_q;
  assign bus.overrun      = overrun_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Self-checking bench for dsp_sequencer: scenario table, hand-written corner sequences
// and random traffic, all checked every cycle against a frame-timing reference model.
module tb_dsp_sequencer;
  import dsp_pkg::*;

  localparam int AW    = 10;
  localparam int D     = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dsp_sequencer_if #(.INSTR_ADDR_WIDTH(AW)) bus ();

  dsp_sequencer #(
    .INSTR_ADDR_WIDTH(AW),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  // Synchronous instruction RAM with one cycle of read latency.
  instr_t mem [DEPTH];
  always @(posedge clk) bus.imem_rd_data <= mem[bus.imem_rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one frame accepted at cycle m_t with length m_L.
  bit m_active = 1'b0;
  int m_t = 0;
  int m_L = 0;
  bit m_ovr = 1'b0;

  typedef struct {
    int len;
    int strobe2_off;
    int newlen_off;
    int newlen;
    int exp_done_off;
    int exp_issued;
    bit exp_ovr;
  } scen_t;

  scen_t scen [6];

  function automatic bit exp_busy(int c);
    return m_active && (c >= m_t + 1) && (c <= m_t + m_L + 2 + D);
  endfunction

  function automatic logic [AW-1:0] exp_addr(int c);
    int k;
    k = c - m_t - 1;
    if (m_active && k >= 0 && k < m_L) return k[AW-1:0];
    return '0;
  endfunction

  function automatic instr_t exp_instr(int c);
    int k;
    k = c - m_t - 3;
    if (m_active && k >= 0 && k < m_L) return mem[k];
    return INSTR_NOP;
  endfunction

  function automatic bit exp_done(int c);
    return m_active && (c == m_t + m_L + 3 + D);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    check("busy", 32'(bus.busy), 32'(exp_busy(cyc)));
    check("imem_rd_addr", 32'(bus.imem_rd_addr), 32'(exp_addr(cyc)));
    check("instr_out", {6'b0, bus.instr_out}, {6'b0, exp_instr(cyc)});
    check("frame_done", 32'(bus.frame_done), 32'(exp_done(cyc)));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  // Apply the inputs that are being driven in the current cycle to the model.
  task automatic model_inputs();
    bit b;
    if (reset) begin
      m_active = 1'b0;
      m_ovr    = 1'b0;
      return;
    end
    b = exp_busy(cyc);
    if (bus.frame_strobe && b) m_ovr = 1'b1;
    else if (bus.overrun_clear) m_ovr = 1'b0;
    if (bus.frame_strobe && !b) begin
      m_active = 1'b1;
      m_t      = cyc;
      m_L      = int'(bus.program_length);
    end
  endtask

  task automatic tick();
    model_inputs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_scen(input scen_t s);
    int t;
    int done_off;
    int issued;
    int budget;
    bus.program_length = (AW + 1)'(s.len);
    bus.frame_strobe   = 1'b1;
    t        = cyc;
    done_off = -1;
    issued   = 0;
    budget   = s.len + 3 + D + 20;
    for (int i = 0; i < budget && done_off < 0; i++) begin
      tick();
      bus.frame_strobe = 1'b0;
      if (bus.instr_out != INSTR_NOP) issued++;
      if (bus.frame_done) done_off = cyc - t;
      if (cyc - t == s.strobe2_off) bus.frame_strobe = 1'b1;
      if (cyc - t == s.newlen_off) bus.program_length = (AW + 1)'(s.newlen);
    end
    bus.frame_strobe = 1'b0;
    check("done_offset", 32'(done_off), 32'(s.exp_done_off));
    check("issued_count", 32'(issued), 32'(s.exp_issued));
    check("overrun_after_frame", 32'(bus.overrun), 32'(s.exp_ovr));
  endtask

  task automatic wait_done(input int t, input int exp_off);
    int got;
    got = -1;
    for (int i = 0; i < exp_off + 20 && got < 0; i++) begin
      tick();
      if (bus.frame_done) got = cyc - t;
    end
    check("done_offset_seq", 32'(got), 32'(exp_off));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int t;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = '{opcode: OP_MAC, sample_addr: 10'(k), param_addr: 10'(k + 100)};
    end
    scen[0] = '{len: 5,    strobe2_off: -1, newlen_off: -1, newlen: 0, exp_done_off: 12,   exp_issued: 5,    exp_ovr: 1'b0};
    scen[1] = '{len: 0,    strobe2_off: -1, newlen_off: -1, newlen: 0, exp_done_off: 7,    exp_issued: 0,    exp_ovr: 1'b0};
    scen[2] = '{len: 1024, strobe2_off: -1, newlen_off: -1, newlen: 0, exp_done_off: 1031, exp_issued: 1024, exp_ovr: 1'b0};
    scen[3] = '{len: 8,    strobe2_off: 4,  newlen_off: -1, newlen: 0, exp_done_off: 15,   exp_issued: 8,    exp_ovr: 1'b1};
    scen[4] = '{len: 3,    strobe2_off: -1, newlen_off: 2,  newlen: 9, exp_done_off: 10,   exp_issued: 3,    exp_ovr: 1'b0};
    scen[5] = '{len: 1,    strobe2_off: -1, newlen_off: -1, newlen: 0, exp_done_off: 8,    exp_issued: 1,    exp_ovr: 1'b0};

    // Clock/reset.
    reset              = 1'b1;
    bus.frame_strobe   = 1'b0;
    bus.program_length = '0;
    bus.overrun_clear  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_cycle();
    check("reset_state", 32'(bus.dbg_state), 32'(SEQ_IDLE));

    // Scenario table.
    for (int i = 0; i < 6; i++) begin
      run_scen(scen[i]);
      if (scen[i].exp_ovr) begin
        bus.overrun_clear = 1'b1;
        tick();
        bus.overrun_clear = 1'b0;
        check("overrun_clear", 32'(bus.overrun), 32'd0);
      end
      tick();
      tick();
    end

    // Set beats clear, then a strobe in the frame_done cycle is accepted.
    bus.program_length = 2;
    bus.frame_strobe   = 1'b1;
    t = cyc;
    tick();
    bus.frame_strobe  = 1'b1;
    bus.overrun_clear = 1'b1;
    tick();
    bus.frame_strobe  = 1'b0;
    bus.overrun_clear = 1'b0;
    check("set_wins_over_clear", 32'(bus.overrun), 32'd1);
    bus.overrun_clear = 1'b1;
    tick();
    bus.overrun_clear = 1'b0;
    check("overrun_cleared", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 20 && (cyc - t) < 2 + 3 + D; i++) tick();
    check("done_before_restrobe", 32'(bus.frame_done), 32'd1);
    bus.program_length = 3;
    bus.frame_strobe   = 1'b1;
    t = cyc;
    tick();
    bus.frame_strobe = 1'b0;
    check("restrobe_busy", 32'(bus.busy), 32'd1);
    check("restrobe_no_overrun", 32'(bus.overrun), 32'd0);
    wait_done(t, 3 + 3 + D);
    tick();

    // Reset mid-frame. An overrun is set first so its reset can be observed.
    bus.program_length = 8;
    bus.frame_strobe   = 1'b1;
    t = cyc;
    tick();
    tick();
    bus.frame_strobe = 1'b0;
    for (int i = 0; i < 10 && (cyc - t) < 5; i++) tick();
    check("overrun_before_reset", 32'(bus.overrun), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_addr", 32'(bus.imem_rd_addr), 32'd0);
    check("rst_instr", {6'b0, bus.instr_out}, {6'b0, INSTR_NOP});
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    m_active = 1'b0;
    m_ovr    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    run_scen(scen[0]);
    tick();

    // Random traffic with random RAM contents.
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = '{opcode: opcode_t'(6'($urandom_range(0, 6))),
                 sample_addr: 10'($urandom_range(0, 1023)),
                 param_addr: 10'($urandom_range(0, 1023))};
    end
    for (int i = 0; i < 2000; i++) begin
      bus.frame_strobe   = ($urandom_range(0, 9) == 0);
      bus.program_length = (AW + 1)'($urandom_range(0, 24));
      bus.overrun_clear  = ($urandom_range(0, 11) == 0);
      tick();
    end
    bus.frame_strobe  = 1'b0;
    bus.overrun_clear = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
